cmd_port_hub: RTL and testbench
===============================

# cmd_port_hub

Parametrised port-bus hub that sits between a KCPSM6 processor's I/O port interface and up to eight byte-wide peripheral channels. It decodes processor writes into per-channel output pulses and captures per-channel input bytes into holding registers with full/overrun status. It also aggregates channel input events into a maskable, acknowledged interrupt line. This generalises the fixed single-port wiring of the current command-control block to N channels with interrupt support.

## Interface
- NUM_CH, 4, number of channels, legal 1..8
- BASE_ADDR, 8'h00, port_id base; must be 32-aligned (BASE_ADDR[4:0]=0)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- port_id  in  8  processor port address
- port_out  in  8  processor write data
- port_in  out  8  read data to processor
- write_strobe  in  1  OUTPUT instruction strobe
- k_write_strobe  in  1  OUTPUTK strobe (uses port_id[3:0] only)
- read_strobe  in  1  INPUT instruction strobe
- interrupt  out  1  interrupt request to processor
- interrupt_ack  in  1  processor interrupt acknowledge
- ch_out_data  out  8*NUM_CH  per-channel written byte, channel c at [8c+7:8c]
- ch_out_valid  out  NUM_CH  one-cycle pulse per channel write
- ch_in_data  in  8*NUM_CH  per-channel input byte
- ch_in_valid  in  NUM_CH  input byte present (single-cycle qualifier)
- ch_in_ready  out  NUM_CH  holding register empty

## Operation
- Decode: hit when port_id[7:5]==BASE_ADDR[7:5]; offset=port_id[4:0].
- Map: 2c = DATA c; 2c+1 = STATUS c (bit0 in_full, bit1 overrun, others 0); 0x10 IRQ_PEND (R, W1C); 0x11 IRQ_MASK (R/W); 0x12 ID (reads NUM_CH). Unmapped or c>=NUM_CH: reads 0x00, writes ignored.
- write_strobe to DATA c: ch_out_data[c]<=port_out, ch_out_valid[c] pulses next cycle.
- k_write_strobe: port_id[3:0]=c (c<NUM_CH) acts as DATA c write; 4'hF clears all IRQ_PEND; others ignored. port_id[7:4] ignored.
- Input capture: ch_in_valid[c] with in_full=0 -> hold<=ch_in_data[c], in_full<=1. With in_full=1 -> data dropped, overrun<=1. Either case sets IRQ_PEND[c].
- ch_in_ready[c] = ~in_full[c] (combinational from register).
- read_strobe on DATA c clears in_full[c]; on STATUS c clears overrun[c]. Other reads side-effect free.
- Simultaneous ch_in_valid and DATA-read clear on same channel: clear applies to old byte, new byte captured, in_full stays 1, no overrun.
- IRQ_PEND: set beats W1C clear in the same cycle.
- interrupt register next = |(IRQ_PEND & IRQ_MASK) & ~interrupt_ack; re-asserts cycle after ack if source still pending.

## Timing
- Reset values: port_in 0, interrupt 0, ch_out_data 0, ch_out_valid 0, ch_in_ready all 1; in_full, overrun, IRQ_PEND, IRQ_MASK all 0.
- port_in registered: reflects port_id of previous cycle (1-cycle latency; KCPSM6 holds port_id 2 cycles, so valid before read_strobe sample).
- Strobe side effects occur on the clock edge where the strobe is high; ch_out_valid and status updates visible 1 cycle later.
- interrupt rises 1 cycle after pending&mask becomes nonzero; falls 1 cycle after interrupt_ack.
- Reset asserted mid-transfer: all state cleared immediately, pending input bytes lost, no ch_out_valid emitted.

## Test plan
- Reset: drive reset=0 mid-activity -> all outputs at reset values asynchronously; ch_in_ready=4'hF (NUM_CH=4).
- Write 0xA5 to port 0x04 -> ch_out_data[23:16]=0xA5, ch_out_valid=4'b0100 for exactly 1 cycle; OUTPUTK port_id 4'h1 data 0x3C -> channel 1 = 0x3C.
- ch_in_valid[1] with 0x5A -> STATUS1=0x01, ch_in_ready[1]=0; read port 0x02 -> port_in=0x5A, then STATUS1=0x00.
- Two ch_in_valid[0] (0x11, 0x22) without read -> DATA0=0x11, STATUS0=0x03; read STATUS0 -> overrun cleared, STATUS0=0x01.
- IRQ_MASK=0x04, ch_in_valid[2] -> interrupt=1 next cycle; ack without clearing -> drops 1 cycle, re-asserts; write 0x04 to 0x10 -> stays 0.
- Same-cycle ch_in_valid[3] and W1C of bit3 -> IRQ_PEND[3]=1; read 0x12 -> 0x04; read unmapped 0x1F -> 0x00.

Source files
------------

// File: rtl/cmd_port_hub_if.sv
// Bus bundle between a KCPSM6 port interface (plus peripheral channels) and cmd_port_hub.
// ch_in_valid is a single-cycle qualifier: a byte is offered for exactly the cycle it is high and
// is never held waiting for ready; ch_in_ready is status only (holding register empty), so a byte
// offered while ready=0 is dropped and flagged as overrun.
interface cmd_port_hub_if #(parameter int NUM_CH = 4);
   logic [7:0]          port_id;
   logic [7:0]          port_out;
   logic [7:0]          port_in;
   logic                write_strobe;
   logic                k_write_strobe;
   logic                read_strobe;
   logic                interrupt;
   logic                interrupt_ack;
   logic [8*NUM_CH-1:0] ch_out_data;
   logic [NUM_CH-1:0]   ch_out_valid;
   logic [8*NUM_CH-1:0] ch_in_data;
   logic [NUM_CH-1:0]   ch_in_valid;
   logic [NUM_CH-1:0]   ch_in_ready;

   modport master (
      output port_id, port_out, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
             ch_in_data, ch_in_valid,
      input  port_in, interrupt, ch_out_data, ch_out_valid, ch_in_ready
   );

   modport slave (
      input  port_id, port_out, write_strobe, k_write_strobe, read_strobe, interrupt_ack,
             ch_in_data, ch_in_valid,
      output port_in, interrupt, ch_out_data, ch_out_valid, ch_in_ready
   );
endinterface

// File: rtl/cmd_port_hub.sv
// KCPSM6 port-bus hub: decodes writes into per-channel output pulses, captures channel input
// bytes into holding registers with full/overrun status, and raises a maskable interrupt.
module cmd_port_hub #(
   parameter int         NUM_CH    = 4,     // 1..8
   parameter logic [7:0] BASE_ADDR = 8'h00  // low five bits must be zero
) (
   input logic          clk,
   input logic          reset,
   cmd_port_hub_if.slave bus
);
   localparam logic [2:0] BASE_HI = BASE_ADDR[7:5];

   logic [7:0]          hold [NUM_CH];
   logic [NUM_CH-1:0]   in_full, overrun, irq_pend, irq_mask;
   logic [8*NUM_CH-1:0] out_data;
   logic [NUM_CH-1:0]   out_valid;
   logic [7:0]          port_in_q;
   logic                interrupt_q;

   logic                hit;
   logic [4:0]          offset;
   logic [NUM_CH-1:0]   wr_vec, rd_data_clr, rd_stat_clr, pend_clr, full_kept;
   logic                mask_we;
   logic [7:0]          rd_mux;

   assign hit    = (bus.port_id[7:5] == BASE_HI);
   assign offset = bus.port_id[4:0];

   always_comb begin
      wr_vec      = '0;
      rd_data_clr = '0;
      rd_stat_clr = '0;
      pend_clr    = '0;
      mask_we     = 1'b0;
      rd_mux      = 8'h00;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.write_strobe && hit && offset == 5'(2*c))     wr_vec[c] = 1'b1;
         // OUTPUTK carries only a 4-bit port number, so it bypasses the base decode
         if (bus.k_write_strobe && bus.port_id[3:0] == 4'(c)) wr_vec[c] = 1'b1;
         if (bus.read_strobe && hit && offset == 5'(2*c))      rd_data_clr[c] = 1'b1;
         if (bus.read_strobe && hit && offset == 5'(2*c+1))    rd_stat_clr[c] = 1'b1;
         if (hit && offset == 5'(2*c))                         rd_mux = hold[c];
         if (hit && offset == 5'(2*c+1))                       rd_mux = {6'b0, overrun[c], in_full[c]};
      end
      if (bus.write_strobe && hit && offset == 5'h10) pend_clr = bus.port_out[NUM_CH-1:0];
      if (bus.k_write_strobe && bus.port_id[3:0] == 4'hF) pend_clr = '1;
      if (bus.write_strobe && hit && offset == 5'h11) mask_we = 1'b1;
      if (hit && offset == 5'h10) rd_mux = 8'(irq_pend);
      if (hit && offset == 5'h11) rd_mux = 8'(irq_mask);
      if (hit && offset == 5'h12) rd_mux = 8'(NUM_CH);
   end

   // A data read in the same cycle as a new byte frees the old byte first, so the new one fits.
   assign full_kept = in_full & ~rd_data_clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) hold[c] <= 8'h00;
         in_full     <= '0;
         overrun     <= '0;
         irq_pend    <= '0;
         irq_mask    <= '0;
         out_data    <= '0;
         out_valid   <= '0;
         port_in_q   <= 8'h00;
         interrupt_q <= 1'b0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_vec[c]) out_data[8*c +: 8] <= bus.port_out;
            if (bus.ch_in_valid[c] && !full_kept[c]) hold[c] <= bus.ch_in_data[8*c +: 8];
         end
         out_valid   <= wr_vec;
         in_full     <= full_kept | bus.ch_in_valid;
         overrun     <= (overrun & ~rd_stat_clr) | (bus.ch_in_valid & full_kept);
         irq_pend    <= (irq_pend & ~pend_clr) | bus.ch_in_valid;
         if (mask_we) irq_mask <= bus.port_out[NUM_CH-1:0];
         port_in_q   <= rd_mux;
         interrupt_q <= (|(irq_pend & irq_mask)) & ~bus.interrupt_ack;
      end
   end

   assign bus.port_in      = port_in_q;
   assign bus.interrupt    = interrupt_q;
   assign bus.ch_out_data  = out_data;
   assign bus.ch_out_valid = out_valid;
   assign bus.ch_in_ready  = ~in_full;
endmodule

// File: tb/tb_cmd_port_hub.sv
// Directed plus randomized bench for cmd_port_hub (NUM_CH=4, BASE_ADDR=0) against a
// transaction-level model of the register map.
module tb_cmd_port_hub;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cmd_port_hub_if #(.NUM_CH(4)) bus ();
   cmd_port_hub #(.NUM_CH(4), .BASE_ADDR(8'h00)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;

   // model state
   logic [7:0]  m_hold [4];
   logic [3:0]  m_full, m_ovr, m_pend, m_mask;
   logic [31:0] m_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      for (int c = 0; c < 4; c++) m_hold[c] = 8'h00;
      m_full = 0; m_ovr = 0; m_pend = 0; m_mask = 0; m_out = 0;
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int c;
      if (a[7:5] != 3'b000) return 8'h00;
      if (a[4:0] < 5'd8) begin
         c = int'(a[4:1]);
         if (a[0]) return {6'b0, m_ovr[c], m_full[c]};
         return m_hold[c];
      end
      case (a[4:0])
         5'h10:   return {4'b0, m_pend};
         5'h11:   return {4'b0, m_mask};
         5'h12:   return 8'd4;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_capture(input int c, input logic [7:0] d);
      if (m_full[c]) m_ovr[c] = 1'b1;
      else begin
         m_hold[c] = d;
         m_full[c] = 1'b1;
      end
      m_pend[c] = 1'b1;
   endtask

   task automatic io_write(input logic [7:0] a, input logic [7:0] d, input logic k);
      logic [3:0] ev;
      bus.port_id = a; bus.port_out = d;
      bus.write_strobe = !k; bus.k_write_strobe = k;
      tick;
      bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0;
      ev = 4'b0;
      if (k) begin
         if (a[3:0] < 4'd4) ev[a[3:0]] = 1'b1;
         else if (a[3:0] == 4'hF) m_pend = 4'b0;
      end else if (a[7:5] == 3'b000) begin
         if (a[4:0] < 5'd8 && !a[0]) ev[a[2:1]] = 1'b1;
         if (a[4:0] == 5'h10) m_pend = m_pend & ~d[3:0];
         if (a[4:0] == 5'h11) m_mask = d[3:0];
      end
      for (int c = 0; c < 4; c++) if (ev[c]) m_out[8*c +: 8] = d;
      check("out_valid", 32'(bus.ch_out_valid), 32'(ev));
      check("out_data", bus.ch_out_data, m_out);
      tick;
      check("out_valid_pulse_end", 32'(bus.ch_out_valid), 32'h0);
   endtask

   task automatic io_read(input logic [7:0] a, input string tag);
      logic [7:0] exp;
      bus.port_id = a;
      tick;
      exp = model_read(a);
      bus.read_strobe = 1'b1;
      check(tag, 32'(bus.port_in), 32'(exp));
      tick;
      bus.read_strobe = 1'b0;
      if (a[7:5] == 3'b000 && a[4:0] < 5'd8) begin
         if (a[0]) m_ovr[a[2:1]] = 1'b0;
         else      m_full[a[2:1]] = 1'b0;
      end
   endtask

   task automatic push(input int c, input logic [7:0] d);
      bus.ch_in_valid[c] = 1'b1;
      bus.ch_in_data[8*c +: 8] = d;
      tick;
      bus.ch_in_valid = 4'b0;
      model_capture(c, d);
      check("in_ready", 32'(bus.ch_in_ready), 32'(4'(~m_full)));
   endtask

   initial begin
      logic [7:0] a, d;
      int op, c;
      bus.port_id = 0; bus.port_out = 0; bus.write_strobe = 0; bus.k_write_strobe = 0;
      bus.read_strobe = 0; bus.interrupt_ack = 0; bus.ch_in_data = 0; bus.ch_in_valid = 0;
      model_reset;
      reset = 1'b0;
      #1;
      check("rst_port_in", 32'(bus.port_in), 32'h0);
      check("rst_interrupt", 32'(bus.interrupt), 32'h0);
      check("rst_out_valid", 32'(bus.ch_out_valid), 32'h0);
      check("rst_in_ready", 32'(bus.ch_in_ready), 32'hF);
      tick;
      reset = 1'b1;
      tick;

      // channel writes: normal and OUTPUTK (upper nibble ignored)
      io_write(8'h04, 8'hA5, 1'b0);
      check("ch2_data", 32'(bus.ch_out_data[23:16]), 32'hA5);
      io_write(8'hF1, 8'h3C, 1'b1);
      check("ch1_data", 32'(bus.ch_out_data[15:8]), 32'h3C);
      io_write(8'h24, 8'h55, 1'b0);   // off-base, ignored

      // capture then read back
      push(1, 8'h5A);
      io_read(8'h03, "status1_full");
      io_read(8'h02, "data1");
      io_read(8'h03, "status1_empty");

      // overrun
      push(0, 8'h11);
      push(0, 8'h22);
      io_read(8'h01, "status0_ovr");
      io_read(8'h01, "status0_ovr_clr");
      io_read(8'h00, "data0_first");

      // interrupt with ack and W1C
      io_write(8'h11, 8'h04, 1'b0);
      tick;
      check("irq_idle", 32'(bus.interrupt), 32'h0);
      push(2, 8'h77);
      check("irq_not_yet", 32'(bus.interrupt), 32'h0);
      tick;
      check("irq_rise", 32'(bus.interrupt), 32'h1);
      bus.interrupt_ack = 1'b1;
      tick;
      bus.interrupt_ack = 1'b0;
      check("irq_ack_drop", 32'(bus.interrupt), 32'h0);
      tick;
      check("irq_reassert", 32'(bus.interrupt), 32'h1);
      io_write(8'h10, 8'h04, 1'b0);
      check("irq_w1c_fall", 32'(bus.interrupt), 32'h0);
      tick;
      check("irq_w1c_stays", 32'(bus.interrupt), 32'h0);

      // set beats W1C on the same cycle
      bus.port_id = 8'h10; bus.port_out = 8'h08; bus.write_strobe = 1'b1;
      bus.ch_in_valid[3] = 1'b1; bus.ch_in_data[31:24] = 8'h99;
      tick;
      bus.write_strobe = 1'b0; bus.ch_in_valid = 4'b0;
      m_pend = m_pend & ~4'h8;
      model_capture(3, 8'h99);
      io_read(8'h10, "irq_pend_set_wins");
      io_read(8'h12, "id");
      io_read(8'h1F, "unmapped");
      io_read(8'h11, "irq_mask");

      // capture and data read on the same cycle (ch2 holds 0x77)
      bus.port_id = 8'h04;
      tick;
      bus.read_strobe = 1'b1;
      bus.ch_in_valid[2] = 1'b1; bus.ch_in_data[23:16] = 8'h66;
      check("data2_old", 32'(bus.port_in), 32'h77);
      tick;
      bus.read_strobe = 1'b0; bus.ch_in_valid = 4'b0;
      m_full[2] = 1'b0;
      model_capture(2, 8'h66);
      io_read(8'h05, "status2_no_ovr");
      io_read(8'h04, "data2_new");

      // reset in the middle of a write and a capture
      bus.port_id = 8'h00; bus.port_out = 8'hEE; bus.write_strobe = 1'b1;
      bus.ch_in_valid[0] = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_out_data", bus.ch_out_data, 32'h0);
      check("mid_rst_in_ready", 32'(bus.ch_in_ready), 32'hF);
      check("mid_rst_port_in", 32'(bus.port_in), 32'h0);
      tick;
      check("mid_rst_no_valid", 32'(bus.ch_out_valid), 32'h0);
      check("mid_rst_interrupt", 32'(bus.interrupt), 32'h0);
      bus.write_strobe = 1'b0; bus.ch_in_valid = 4'b0;
      model_reset;
      reset = 1'b1;
      tick;

      // randomized traffic against the model
      io_write(8'h11, 8'($urandom_range(0, 15)), 1'b0);
      for (int n = 0; n < 200; n++) begin
         op = $urandom_range(0, 7);
         c  = $urandom_range(0, 3);
         d  = 8'($urandom);
         case (op)
            0, 1: push(c, d);
            2:    io_read(8'(2*c), "rnd_data");
            3:    io_read(8'(2*c+1), "rnd_status");
            4:    io_write(8'(2*c), d, 1'b0);
            5: begin
               a = 8'($urandom);
               io_write(a, d, 1'b1);
            end
            6:    io_write(8'h10 + 8'($urandom_range(0, 1)), d, 1'b0);
            default: begin
               a = 8'($urandom_range(0, 31));
               io_read(a, "rnd_any");
            end
         endcase
         tick;
         check("rnd_interrupt", 32'(bus.interrupt), 32'(|(m_pend & m_mask)));
         check("rnd_in_ready", 32'(bus.ch_in_ready), 32'(4'(~m_full)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
